// File: rtl/ctrl_fsm_hs_if.sv
// Program-memory and data-memory handshake bundle between ctrl_fsm_hs and its memories.
// Handshake: a request (pm_req / mem_req) stays high until a rising edge on which the matching
// ready is high; that edge completes the access. Ready outside a request is ignored.
interface ctrl_fsm_hs_if #(
  parameter int PC_WIDTH = 8
);
  logic                pm_req;
  logic [PC_WIDTH-1:0] pm_addr;
  logic                pm_ready;
  logic [15:0]         pm_data;
  logic                mem_req;
  logic                mem_write;
  logic                mem_ready;

  modport master (
    output pm_req, pm_addr, mem_req, mem_write,
    input  pm_ready, pm_data, mem_ready
  );

  modport slave (
    input  pm_req, pm_addr, mem_req, mem_write,
    output pm_ready, pm_data, mem_ready
  );
endinterface

// File: rtl/ctrl_fsm_hs.sv
// Multi-cycle control unit: fetches 16-bit instructions over a ready/valid program-memory port,
// decodes them and sequences register-file, ALU and data-memory controls, branches, jumps and halt.
module ctrl_fsm_hs #(
  parameter int PC_WIDTH   = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  ctrl_fsm_hs_if.master         bus,
  input  logic                  zero_flag,
  input  logic                  pos_flag,
  output logic                  rf_write,
  output logic [2:0]            rs_addr,
  output logic [2:0]            rt_addr,
  output logic [2:0]            rd_addr,
  output logic [DATA_WIDTH-1:0] imm_data,
  output logic [3:0]            alu_sel,
  output logic                  imm_sel,
  output logic                  mem_sel,
  output logic [PC_WIDTH-1:0]   PC,
  output logic                  halted,
  output logic [2:0]            dbg_state_o
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
  } state_t;

  localparam logic [3:0] OP_LAST_ALU = 4'd8;
  localparam logic [3:0] OP_LD       = 4'd9;
  localparam logic [3:0] OP_ST       = 4'd10;
  localparam logic [3:0] OP_MOV      = 4'd11;
  localparam logic [3:0] OP_BEQ      = 4'd13;
  localparam logic [3:0] OP_BLT_BGT  = 4'd14;
  localparam logic [3:0] OP_J_HALT   = 4'd15;

  state_t                state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [15:0]           instr_q, instr_d;
  logic [2:0]            rs_q, rs_d;
  logic [2:0]            rt_q, rt_d;
  logic [2:0]            rd_q, rd_d;
  logic [DATA_WIDTH-1:0] imm_q, imm_d;
  logic [3:0]            alu_sel_q, alu_sel_d;
  logic                  imm_sel_q, imm_sel_d;
  logic                  mem_sel_q, mem_sel_d;

  logic [3:0]            op;
  logic                  r_bit;
  logic                  branch_taken;
  logic [15:0]           off_ext;
  logic [PC_WIDTH-1:0]   branch_target;

  assign op    = instr_q[15:12];
  assign r_bit = instr_q[11];

  // pc_q already points past the branch, so the target is simply pc_q + offset (mod 2^PC_WIDTH).
  assign off_ext       = {{5{instr_q[10]}}, instr_q[10:0]};
  assign branch_target = pc_q + off_ext[PC_WIDTH-1:0];

  always_comb begin
    branch_taken = 1'b0;
    case (op)
      OP_BEQ:     branch_taken = zero_flag;
      OP_BLT_BGT: branch_taken = r_bit ? (pos_flag & ~zero_flag) : (~pos_flag & ~zero_flag);
      default:    branch_taken = 1'b0;
    endcase
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (bus.pm_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        state_d = S_EXECUTE;
      end
      S_EXECUTE: begin
        if (op <= OP_LAST_ALU || op == OP_MOV) begin
          state_d = S_WRITEBACK;
        end else if (op == OP_LD || op == OP_ST) begin
          state_d = S_MEMORY;
        end else if (op == OP_J_HALT && r_bit) begin
          state_d = S_HALT;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_MEMORY: begin
        if (bus.mem_ready) state_d = (op == OP_LD) ? S_WRITEBACK : S_FETCH;
      end
      S_WRITEBACK: begin
        state_d = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // ---------------- FSM: Moore outputs ----------------
  always_comb begin
    bus.pm_req    = 1'b0;
    bus.mem_req   = 1'b0;
    bus.mem_write = 1'b0;
    rf_write      = 1'b0;
    halted        = 1'b0;
    case (state_q)
      S_FETCH:     bus.pm_req = 1'b1;
      S_MEMORY: begin
        bus.mem_req   = 1'b1;
        bus.mem_write = (op == OP_ST);
      end
      S_WRITEBACK: rf_write = 1'b1;
      S_HALT:      halted = 1'b1;
      default:     ;
    endcase
  end

  // ---------------- Datapath next values ----------------
  always_comb begin
    pc_d      = pc_q;
    instr_d   = instr_q;
    rs_d      = rs_q;
    rt_d      = rt_q;
    rd_d      = rd_q;
    imm_d     = imm_q;
    alu_sel_d = alu_sel_q;
    imm_sel_d = imm_sel_q;
    mem_sel_d = mem_sel_q;
    case (state_q)
      S_FETCH: begin
        if (bus.pm_ready) begin
          instr_d = bus.pm_data;
          pc_d    = pc_q + PC_WIDTH'(1);
        end
      end
      S_DECODE: begin
        imm_sel_d = ~r_bit;
        mem_sel_d = 1'b0;
        rd_d      = instr_q[10:8];
        rt_d      = instr_q[2:0];
        imm_d     = '0;
        // ALU ops carry a separate rs and a 5-bit immediate; the rest reuse rd as rs.
        if (op <= OP_LAST_ALU) begin
          rs_d       = instr_q[7:5];
          imm_d[4:0] = instr_q[4:0];
        end else begin
          rs_d       = instr_q[10:8];
          imm_d[7:0] = instr_q[7:0];
        end
      end
      S_EXECUTE: begin
        alu_sel_d = op;
        if (op == OP_LD) mem_sel_d = 1'b1;
        if (branch_taken) pc_d = branch_target;
        if (op == OP_J_HALT && !r_bit) pc_d = instr_q[PC_WIDTH-1:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_q      <= '0;
      instr_q   <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
      imm_q     <= '0;
      alu_sel_q <= 4'hF;
      imm_sel_q <= 1'b0;
      mem_sel_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      rd_q      <= rd_d;
      imm_q     <= imm_d;
      alu_sel_q <= alu_sel_d;
      imm_sel_q <= imm_sel_d;
      mem_sel_q <= mem_sel_d;
    end
  end

  assign bus.pm_addr = pc_q;
  assign PC          = pc_q;
  assign rs_addr     = rs_q;
  assign rt_addr     = rt_q;
  assign rd_addr     = rd_q;
  assign imm_data    = imm_q;
  assign alu_sel     = alu_sel_q;
  assign imm_sel     = imm_sel_q;
  assign mem_sel     = mem_sel_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ctrl_fsm_hs.sv
// Self-checking bench for ctrl_fsm_hs: directed scenarios plus randomized instruction streams
// checked against an instruction-level reference model.
module tb_ctrl_fsm_hs;
  localparam int PW = 8;
  localparam int DW = 16;

  // ---------------- clock / reset ----------------
  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic          zero_flag, pos_flag;
  logic          rf_write, imm_sel, mem_sel, halted;
  logic [2:0]    rs_addr, rt_addr, rd_addr, dbg_state;
  logic [DW-1:0] imm_data;
  logic [3:0]    alu_sel;
  logic [PW-1:0] PC;

  ctrl_fsm_hs_if #(.PC_WIDTH(PW)) bus_if ();

  ctrl_fsm_hs #(.PC_WIDTH(PW), .DATA_WIDTH(DW)) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus_if),
    .zero_flag(zero_flag), .pos_flag(pos_flag),
    .rf_write(rf_write), .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
    .imm_data(imm_data), .alu_sel(alu_sel), .imm_sel(imm_sel), .mem_sel(mem_sel),
    .PC(PC), .halted(halted), .dbg_state_o(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  int model_pc = 0;
  logic [PW-1:0] exp_q[$];

  // ---------------- reference model ----------------
  function automatic int exp_cycles(input logic [15:0] ins);
    int op;
    op = int'(ins[15:12]);
    if (op == 15 && ins[11]) return 3;
    if (op <= 8 || op == 11) return 4;
    if (op == 9) return 5;
    if (op == 10) return 4;
    return 3;
  endfunction

  function automatic int next_pc(input int pc, input logic [15:0] ins, input bit zf, input bit pf);
    int op, off, m;
    bit taken;
    m = 1 << PW;
    op = int'(ins[15:12]);
    taken = (op == 13 && zf) ||
            (op == 14 && !ins[11] && !pf && !zf) ||
            (op == 14 &&  ins[11] &&  pf && !zf);
    if (op == 15 && !ins[11]) return int'(ins[10:0]) % m;
    if (taken) begin
      off = int'(ins[10:0]);
      if (off >= 1024) off = off - 2048;
      return ((pc + 1 + off) % m + m) % m;
    end
    return (pc + 1) % m;
  endfunction

  // ---------------- driver: one instruction from fetch to its next fetch (or halt) ----------------
  task automatic run_instr(input logic [15:0] ins, input int pm_wait, input int mem_wait,
                           input bit zf, input bit pf);
    int op, cyc, pmw, mw, rf_cnt, mreq_cnt, wr_bad, sel_bad, exp_lat, exp_pc;
    int e_rd, e_rs, e_rt, e_imm;
    bit fetched, done, is_halt, is_mem;
    logic [PW-1:0] e_pc;
    op       = int'(ins[15:12]);
    is_halt  = (op == 15) && ins[11];
    is_mem   = (op == 9) || (op == 10);
    exp_lat  = exp_cycles(ins) + pm_wait + (is_mem ? mem_wait : 0);
    exp_pc   = next_pc(model_pc, ins, zf, pf);
    exp_q.push_back(exp_pc[PW-1:0]);
    zero_flag = zf;
    pos_flag  = pf;

    n_cmp++;
    if (bus_if.pm_req !== 1'b1 || bus_if.pm_addr !== model_pc[PW-1:0]) begin
      n_bad++;
      $display("FAIL fetch_start ins=%h: pm_req=%b pm_addr=%h, want pm_req=1 pm_addr=%h",
               ins, bus_if.pm_req, bus_if.pm_addr, model_pc[PW-1:0]);
    end

    pmw = pm_wait; mw = mem_wait; cyc = 0; fetched = 0; done = 0;
    rf_cnt = 0; mreq_cnt = 0; wr_bad = 0; sel_bad = 0;
    while (!done && cyc < 100) begin
      if (fetched && (bus_if.pm_req === 1'b1 || halted === 1'b1)) begin
        done = 1;
      end else begin
        if (rf_write === 1'b1) begin
          rf_cnt++;
          if (mem_sel !== (op == 9)) sel_bad++;
        end
        if (bus_if.mem_req === 1'b1) begin
          mreq_cnt++;
          if (bus_if.mem_write !== (op == 10)) wr_bad++;
        end
        bus_if.pm_ready  = 1'b0;
        bus_if.pm_data   = 16'($urandom);
        bus_if.mem_ready = 1'b0;
        if (bus_if.pm_req === 1'b1 && !fetched) begin
          if (pmw > 0) pmw--;
          else begin
            bus_if.pm_ready = 1'b1;
            bus_if.pm_data  = ins;
            fetched = 1;
          end
        end else if (bus_if.pm_req !== 1'b1) begin
          bus_if.pm_ready = 1'($urandom_range(0, 1));
        end
        if (bus_if.mem_req === 1'b1) begin
          if (mw > 0) mw--;
          else bus_if.mem_ready = 1'b1;
        end else begin
          bus_if.mem_ready = 1'($urandom_range(0, 1));
        end
        @(posedge clock);
        @(negedge clock);
        cyc++;
      end
    end
    bus_if.pm_ready  = 1'b0;
    bus_if.mem_ready = 1'b0;

    e_pc = exp_q.pop_front();
    n_cmp++;
    if (!done) begin
      n_bad++;
      $display("FAIL timeout ins=%h: no return to fetch/halt after %0d cycles", ins, cyc);
    end
    n_cmp++;
    if (cyc != exp_lat) begin
      n_bad++;
      $display("FAIL latency ins=%h: got %0d cycles, want %0d", ins, cyc, exp_lat);
    end
    n_cmp++;
    if (PC !== e_pc) begin
      n_bad++;
      $display("FAIL next_pc ins=%h from pc=%h: got %h, want %h", ins, model_pc[PW-1:0], PC, e_pc);
    end
    n_cmp++;
    if (rf_cnt != ((op <= 9 || op == 11) ? 1 : 0)) begin
      n_bad++;
      $display("FAIL rf_write_pulses ins=%h: got %0d", ins, rf_cnt);
    end
    n_cmp++;
    if (mreq_cnt != (is_mem ? mem_wait + 1 : 0) || wr_bad != 0 || sel_bad != 0) begin
      n_bad++;
      $display("FAIL mem_access ins=%h: mem_req cycles %0d want %0d, bad mem_write %0d, bad mem_sel at wb %0d",
               ins, mreq_cnt, is_mem ? mem_wait + 1 : 0, wr_bad, sel_bad);
    end
    n_cmp++;
    if (alu_sel !== ins[15:12] || mem_sel !== (op == 9) || halted !== is_halt) begin
      n_bad++;
      $display("FAIL exec_regs ins=%h: alu_sel=%h mem_sel=%b halted=%b, want %h %b %b",
               ins, alu_sel, mem_sel, halted, ins[15:12], op == 9, is_halt);
    end
    if (op <= 12) begin
      e_rd  = (int'(ins) >> 8) & 7;
      e_rs  = (op <= 8) ? ((int'(ins) >> 5) & 7) : e_rd;
      e_rt  = int'(ins) & 7;
      e_imm = (op <= 8) ? (int'(ins) & 31) : (int'(ins) & 255);
      n_cmp++;
      if (rd_addr !== 3'(e_rd) || rs_addr !== 3'(e_rs) || rt_addr !== 3'(e_rt) ||
          imm_data !== DW'(e_imm) || imm_sel !== !ins[11]) begin
        n_bad++;
        $display("FAIL decode ins=%h: rd=%0d rs=%0d rt=%0d imm=%h imm_sel=%b, want %0d %0d %0d %h %b",
                 ins, rd_addr, rs_addr, rt_addr, imm_data, imm_sel, e_rd, e_rs, e_rt, e_imm, !ins[11]);
      end
    end
    model_pc = exp_pc;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    bus_if.pm_ready = 1'b0; bus_if.pm_data = '0; bus_if.mem_ready = 1'b0;
    zero_flag = 1'b0; pos_flag = 1'b0;
    reset_n = 1'b0;
    #23;
    n_cmp++;
    if (bus_if.pm_req !== 1'b1 || PC !== '0 || alu_sel !== 4'hF || imm_data !== '0 ||
        rd_addr !== 3'd0 || rs_addr !== 3'd0 || rt_addr !== 3'd0 || imm_sel !== 1'b0 ||
        mem_sel !== 1'b0 || rf_write !== 1'b0 || bus_if.mem_req !== 1'b0 ||
        bus_if.mem_write !== 1'b0 || halted !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_values: pm_req=%b PC=%h alu_sel=%h imm=%h rd/rs/rt=%0d/%0d/%0d imm_sel=%b mem_sel=%b rf=%b mreq=%b mw=%b halted=%b",
               bus_if.pm_req, PC, alu_sel, imm_data, rd_addr, rs_addr, rt_addr, imm_sel, mem_sel,
               rf_write, bus_if.mem_req, bus_if.mem_write, halted);
    end
    @(negedge clock);
    reset_n  = 1'b1;
    model_pc = 0;
  endtask

  task automatic test_add_zero_wait;
    run_instr(16'h0A25, 0, 0, 1'b0, 1'b0);
    n_cmp++;
    if (rd_addr !== 3'd2 || rs_addr !== 3'd1 || rt_addr !== 3'd5 || imm_sel !== 1'b0 ||
        alu_sel !== 4'd0 || PC !== 8'd1) begin
      n_bad++;
      $display("FAIL add_fields: rd=%0d rs=%0d rt=%0d imm_sel=%b alu_sel=%0d PC=%0d, want 2 1 5 0 0 1",
               rd_addr, rs_addr, rt_addr, imm_sel, alu_sel, PC);
    end
  endtask

  task automatic test_ld_wait;
    run_instr(16'h9312, 0, 3, 1'b0, 1'b0);
    n_cmp++;
    if (imm_data !== 16'h0012 || mem_sel !== 1'b1 || imm_sel !== 1'b1) begin
      n_bad++;
      $display("FAIL ld_fields: imm=%h mem_sel=%b imm_sel=%b, want 0012 1 1", imm_data, mem_sel, imm_sel);
    end
  endtask

  task automatic test_reset_mid_access;
    int cyc;
    bus_if.mem_ready = 1'b0;
    bus_if.pm_ready  = 1'b1;
    bus_if.pm_data   = 16'h9A00;
    @(posedge clock); @(negedge clock);
    bus_if.pm_ready = 1'b0;
    cyc = 0;
    while (bus_if.mem_req !== 1'b1 && cyc < 10) begin
      @(posedge clock); @(negedge clock);
      cyc++;
    end
    @(posedge clock); @(negedge clock);
    n_cmp++;
    if (bus_if.mem_req !== 1'b1) begin
      n_bad++;
      $display("FAIL reach_memory: mem_req=%b, want 1", bus_if.mem_req);
    end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if (bus_if.mem_req !== 1'b0 || bus_if.pm_req !== 1'b1 || PC !== '0 ||
        alu_sel !== 4'hF || mem_sel !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset_mid_access: mem_req=%b pm_req=%b PC=%h alu_sel=%h mem_sel=%b, want 0 1 0 f 0",
               bus_if.mem_req, bus_if.pm_req, PC, alu_sel, mem_sel);
    end
    @(negedge clock);
    reset_n  = 1'b1;
    model_pc = 0;
    run_instr(16'h1345, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_branch;
    run_instr(16'hF005, 0, 0, 1'b0, 1'b0);
    run_instr(16'hD7FD, 0, 0, 1'b1, 1'b0);
    n_cmp++;
    if (PC !== 8'd3) begin
      n_bad++;
      $display("FAIL beq_taken: PC=%0d, want 3", PC);
    end
    run_instr(16'hF005, 1, 0, 1'b0, 1'b0);
    run_instr(16'hD7FD, 0, 0, 1'b0, 1'b1);
    n_cmp++;
    if (PC !== 8'd6) begin
      n_bad++;
      $display("FAIL beq_not_taken: PC=%0d, want 6", PC);
    end
    run_instr(16'hE002, 0, 0, 1'b0, 1'b0);
    run_instr(16'hE802, 0, 0, 1'b0, 1'b1);
  endtask

  task automatic test_wrap;
    run_instr(16'hF0FF, 0, 0, 1'b0, 1'b0);
    run_instr(16'h0A25, 2, 0, 1'b0, 1'b0);
    n_cmp++;
    if (PC !== 8'd0) begin
      n_bad++;
      $display("FAIL pc_wrap: PC=%h, want 00", PC);
    end
    run_instr(16'hA1FF, 0, 2, 1'b0, 1'b0);
    run_instr(16'hDFF0, 0, 0, 1'b1, 1'b0);
  endtask

  task automatic test_random;
    logic [15:0] ins;
    for (int i = 0; i < 80; i++) begin
      ins = 16'($urandom);
      if (ins[15:12] == 4'hF) ins[11] = 1'b0;
      run_instr(ins, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_halt;
    int bad;
    run_instr(16'hF008, 0, 0, 1'b0, 1'b0);
    run_instr(16'hF800, 0, 0, 1'b0, 1'b0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      bus_if.pm_ready  = 1'b1;
      bus_if.mem_ready = 1'($urandom_range(0, 1));
      @(posedge clock); @(negedge clock);
      n_cmp++;
      if (halted !== 1'b1 || bus_if.pm_req !== 1'b0 || bus_if.mem_req !== 1'b0 ||
          rf_write !== 1'b0 || PC !== 8'd9) begin
        n_bad++;
        $display("FAIL halt_hold cycle %0d: halted=%b pm_req=%b mem_req=%b rf_write=%b PC=%0d, want 1 0 0 0 9",
                 i, halted, bus_if.pm_req, bus_if.mem_req, rf_write, PC);
      end
    end
    bus_if.pm_ready = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if (halted !== 1'b0 || bus_if.pm_req !== 1'b1 || PC !== '0) begin
      n_bad++;
      $display("FAIL reset_leaves_halt: halted=%b pm_req=%b PC=%h, want 0 1 0", halted, bus_if.pm_req, PC);
    end
    @(negedge clock);
    reset_n  = 1'b1;
    model_pc = 0;
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    test_reset();
    test_add_zero_wait();
    test_ld_wait();
    test_reset_mid_access();
    test_branch();
    test_wrap();
    test_random();
    test_halt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
